// File: rtl/sp_instr_expander.sv
// Scratchpad front-end: expands load/store/gemm instructions into row requests.
// Optional SP_ADDR_ALIGN_CHECK_EN rejects load/store bases not 8-byte aligned.
module sp_instr_expander #(
    parameter int WORD_W  = 32,
    parameter int MAT_S_W = 4,
    parameter int ROW_S_W = 2,
    parameter int STRIDE  = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [1:0]         instr_opcode,
    input  logic [MAT_S_W-1:0] instr_mat,
    input  logic [WORD_W-1:0]  instr_word,
    output logic               lreq_valid,
    input  logic               lreq_ready,
    output logic [WORD_W-1:0]  lreq_addr,
    output logic [MAT_S_W-1:0] lreq_mat_s,
    output logic [ROW_S_W-1:0] lreq_row_s,
    output logic               rreq_valid,
    input  logic               rreq_ready,
    output logic [WORD_W-1:0]  rreq_addr,
    output logic [1:0]         rreq_mat_t,
    output logic [MAT_S_W-1:0] rreq_mat_s,
    output logic [ROW_S_W-1:0] rreq_row_s,
    output logic               gcmd_valid,
    input  logic               gcmd_ready,
    output logic               gcmd_new_weight,
    output logic [3:0]         gcmd_dest,
`ifdef SP_ADDR_ALIGN_CHECK_EN
    output logic               err_misaligned,
`endif
    output logic               busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        GEMM_RD,
        GEMM_CMD
    } state_t;

    state_t               state_q, state_n;
    logic [ROW_S_W-1:0]   row_q, row_n;
    logic [1:0]           type_q, type_n;
    logic [MAT_S_W-1:0]   mat_q;
    logic [WORD_W-1:0]    word_q;
    logic [WORD_W-1:0]    row_addr;
    logic [MAT_S_W-1:0]   sel_mat;
    logic                 accept;
    logic                 bad_align;

    assign instr_ready = (state_q == IDLE) && !RST;
    assign busy        = (state_q != IDLE);
    assign accept      = instr_valid && instr_ready;
    assign row_addr    = word_q + WORD_W'(row_q) * WORD_W'(STRIDE);

`ifdef SP_ADDR_ALIGN_CHECK_EN
    logic err_q;
    assign err_misaligned = err_q;
    assign bad_align = (instr_opcode == 2'b01 || instr_opcode == 2'b10)
                       && (instr_word[2:0] != 3'b000);
`else
    assign bad_align = 1'b0;
`endif

    // Operand matrix for the current gemm read type, from the gemm select
    always_comb begin
        sel_mat = '0;
        unique case (type_q)
            2'b01:   sel_mat = word_q[3:0];
            2'b10:   sel_mat = word_q[7:4];
            2'b11:   sel_mat = word_q[11:8];
            default: sel_mat = '0;
        endcase
    end

    always_comb begin
        state_n         = state_q;
        row_n           = row_q;
        type_n          = type_q;
        lreq_valid      = 1'b0;
        lreq_addr       = '0;
        lreq_mat_s      = '0;
        lreq_row_s      = '0;
        rreq_valid      = 1'b0;
        rreq_addr       = '0;
        rreq_mat_t      = '0;
        rreq_mat_s      = '0;
        rreq_row_s      = '0;
        gcmd_valid      = 1'b0;
        gcmd_new_weight = 1'b0;
        gcmd_dest       = '0;
        unique case (state_q)
            IDLE: begin
                if (accept && !bad_align) begin
                    row_n = '0;
                    unique case (1'b1)
                        instr_opcode == 2'b01: state_n = LOAD;
                        instr_opcode == 2'b10: state_n = STORE;
                        instr_opcode == 2'b11: begin
                            state_n = GEMM_RD;
                            type_n  = instr_mat[3] ? 2'b01 : 2'b10;
                        end
                        default: state_n = IDLE;
                    endcase
                end
            end
            LOAD: begin
                lreq_valid = 1'b1;
                lreq_addr  = row_addr;
                lreq_mat_s = mat_q;
                lreq_row_s = row_q;
                if (lreq_ready) begin
                    row_n = row_q + 1'b1;
                    if (&row_q) state_n = IDLE;
                end
            end
            STORE: begin
                rreq_valid = 1'b1;
                rreq_addr  = row_addr;
                rreq_mat_t = 2'b00;
                rreq_mat_s = mat_q;
                rreq_row_s = row_q;
                if (rreq_ready) begin
                    row_n = row_q + 1'b1;
                    if (&row_q) state_n = IDLE;
                end
            end
            GEMM_RD: begin
                rreq_valid = 1'b1;
                rreq_mat_t = type_q;
                rreq_mat_s = sel_mat;
                rreq_row_s = row_q;
                if (rreq_ready) begin
                    row_n = row_q + 1'b1;
                    if (&row_q) begin
                        if (type_q == 2'b11) state_n = GEMM_CMD;
                        else type_n = type_q + 1'b1;
                    end
                end
            end
            GEMM_CMD: begin
                gcmd_valid      = 1'b1;
                gcmd_new_weight = mat_q[MAT_S_W-1];
                gcmd_dest       = word_q[15:12];
                if (gcmd_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            row_q   <= '0;
            type_q  <= '0;
            mat_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_n;
            row_q   <= row_n;
            type_q  <= type_n;
            if (accept) begin
                mat_q  <= instr_mat;
                word_q <= instr_word;
            end
        end
    end

`ifdef SP_ADDR_ALIGN_CHECK_EN
    always_ff @(posedge CLK) begin
        if (RST) err_q <= 1'b0;
        else     err_q <= accept && bad_align;
    end
`endif

endmodule

// File: doc/sp_instr_expander.md
Name: sp_instr_expander

Overview:
- Scratchpad front-end stage between the instruction FIFO (instrFIFO_t entries) and the scratchpad request queues.
- Expands each matrix load, store or GEMM instruction into per-row requests:
  - DRAM-load row requests.
  - Scratchpad read requests (rFIFO_t format).
  - One GEMM command.
- Processes one instruction at a time, with valid/ready handshakes on every interface.

Parameters:
- WORD_W, 32, address width.
- MAT_S_W, 4, matrix-select width.
- ROW_S_W, 2, row-select width; ROWS = 2**ROW_S_W = 4 rows per matrix.
- STRIDE, 8, byte increment between consecutive rows (one 64-bit row).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction available.
- instr_ready  out  1  instruction accepted when valid&&ready.
- instr_opcode  in  2  01 load, 10 store, 11 gemm, 00 nop.
- instr_mat  in  4  load/store: destination/source mat_s; gemm: bit3 = new_weight, bits[2:0] ignored.
- instr_word  in  32  load/store: matrix base address; gemm: bits[15:0] = gemm select.
- lreq_valid/lreq_ready  out/in  1/1  DRAM load row request handshake.
- lreq_addr  out  32  row DRAM address.
- lreq_mat_s  out  4  destination matrix.
- lreq_row_s  out  2  row index.
- rreq_valid/rreq_ready  out/in  1/1  scratchpad read request handshake.
- rreq_addr  out  32  store: DRAM row address; gemm: 0.
- rreq_mat_t  out  2  00 store; 01/10/11 gemm operand type.
- rreq_mat_s  out  4  source matrix.
- rreq_row_s  out  2  row index.
- gcmd_valid/gcmd_ready  out/in  1/1  GEMM command handshake.
- gcmd_new_weight  out  1  from instr_mat[3].
- gcmd_dest  out  4  gemm select bits[15:12].
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset: state IDLE; row and type counters 0; all valids 0; all data outputs 0; busy 0.
- RST high mid-operation aborts the instruction in flight; no further requests are issued.
- instr_ready = (state==IDLE) && !RST. One instruction per cycle at most.
- Accepting an instruction latches opcode, mat, word.
- Requests are driven from registers: first request valid on the cycle after acceptance.
- Data outputs hold stable while valid && !ready.
- States:
  - IDLE:
    - accept opcode 01 -> LOAD.
    - accept opcode 10 -> STORE.
    - accept opcode 11 -> GEMM_RD, starting type 01 if new_weight else type 10.
    - accept opcode 00 -> stay IDLE; instruction consumed, no output.
  - LOAD:
    - lreq_valid=1; addr = base + row*STRIDE (mod 2^32, wrap permitted); mat_s = latched mat; row_s = row.
    - On handshake: row++. On row 3 handshake -> IDLE.
  - STORE:
    - Same addressing on rreq; mat_t = 00.
    - After row 3 handshake -> IDLE.
  - GEMM_RD:
    - rreq_addr = 0; rreq_mat_s per type: 01 -> sel[3:0], 10 -> sel[7:4], 11 -> sel[11:8].
    - Order: type ascending, rows 0..3 within each type.
    - After type 11 row 3 handshake -> GEMM_CMD.
  - GEMM_CMD:
    - gcmd_valid=1; on handshake -> IDLE.
- Request counts:
  - Load/store: 4 requests each.
  - GEMM: 12 reads with new_weight, 8 without, then exactly 1 gcmd.
- Back-to-back: the next instruction is accepted the cycle after return to IDLE (instr_ready is registered from state). Min gap 1 cycle.
- Ready deassertion at any point stalls in place; no request is dropped or duplicated.

Optional Feature:
- Macro SP_ADDR_ALIGN_CHECK_EN.
- When defined:
  - Adds output err_misaligned (1 bit, reset 0).
  - A load/store accepted with word[2:0] != 0 emits no requests.
  - err_misaligned pulses high for exactly one cycle, the cycle after acceptance.
  - State remains IDLE.
- When undefined:
  - No port; the address is used unmodified.

Test Plan:
- Load opcode 01, mat 4'h5, addr 0x1000, lreq_ready=1 -> lreq addr 0x1000/0x1008/0x1010/0x1018, mat_s 5, row_s 0..3 on consecutive cycles; busy drops after the 4th; no rreq/gcmd.
- Store opcode 10, mat 4'h2, addr 0xFFFF_FFF8 -> rreq mat_t 00; addrs 0xFFFF_FFF8, 0x0, 0x8, 0x10 (wrap); mat_s 2.
- Gemm opcode 11, mat 4'h8, sel 16'hA321 -> 12 rreq: (01,1)x4, (02,2)x4, (03,3)x4; addr 0; then gcmd new_weight 1, dest 4'hA.
- Gemm with mat 4'h0, same sel -> 8 rreq, types 10/11 only; gcmd new_weight 0.
- Store with rreq_ready toggling 1,0,0,1 and RST asserted during row 2 -> outputs held while stalled; next cycle all valids 0, state IDLE, instr_ready 1.
- (SP_ADDR_ALIGN_CHECK_EN) load at addr 0x1004 -> no lreq; err_misaligned high for 1 cycle; a following nop opcode 00 is consumed with no outputs.
